dec_udp_acq_rx: RTL and testbench

// Receive side of the acquisition UDP stream: reads packets from the 1GbE rx FIFOs (status + byte data)
// in the same format our port-2 acquisition encoder transmits (mode byte, 32-bit freq, raw or demodulated

---
 rtl/dec_udp_acq_rx.sv | 241 ++++++++++++++++++++++++
 tb/tb_dec_udp_acq_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_udp_acq_rx.sv
// Acquisition UDP receive decoder: pulls status and payload bytes from the
// 1GbE rx FIFOs and rebuilds 108-bit acquisition words for the output FIFO.
module dec_udp_acq_rx #(
   parameter int AVL_SIZE            = 8,
   parameter int BYTE_SIZE           = 8,
   parameter int IP_SIZE             = 32,
   parameter int MAC_SIZE            = 48,
   parameter int UDP_BYTE_PER_PACKET = 3957
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic [IP_SIZE-1:0]                     expected_ip,
   input  logic [AVL_SIZE-1:0]                    rx_fifo_data,
   input  logic                                   rx_fifo_data_empty,
   output logic                                   rx_fifo_data_read,
   input  logic [2*BYTE_SIZE+IP_SIZE+MAC_SIZE-1:0] rx_fifo_status,
   input  logic                                   rx_fifo_status_empty,
   output logic                                   rx_fifo_status_read,
   output logic                                   acq_wrreq_fifo_108,
   output logic [107:0]                           acq_wrdata_fifo_108,
   input  logic                                   acq_wrfull_fifo_108,
   output logic                                   rx_mode_nCont_disc,
   output logic                                   rx_mode_nRaw_dem,
   output logic [15:0]                            pkt_count,
   output logic [15:0]                            err_count
);

   localparam int LW = 2 * BYTE_SIZE;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CHECK  = 3'd1;
   localparam logic [2:0] S_MODE   = 3'd2;
   localparam logic [2:0] S_FREQ   = 3'd3;
   localparam logic [2:0] S_SAMPLE = 3'd4;
   localparam logic [2:0] S_WRITE  = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;
   localparam logic [2:0] S_FLUSH  = 3'd7;

   logic [2:0]    state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [31:0]   ip_q, ip_d;
   logic [LW-1:0] left_q, left_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [1:0]    mode_q, mode_d;
   logic [31:0]   freq_q, freq_d;
   logic [31:0]   lfreq_q, lfreq_d;
   logic          lvld_q, lvld_d;
   logic          fc_q, fc_d;
   logic [63:0]   smp_q, smp_d;
   logic          srd_q, srd_d;
   logic          ncont_q, ncont_d;
   logic          nraw_q, nraw_d;
   logic [15:0]   pkt_q, pkt_d;
   logic [15:0]   err_q, err_d;

   logic [7:0]    byte_w;
   logic [LW-1:0] st_len;
   logic [31:0]   st_ip;
   logic [LW-1:0] lm5;
   logic [31:0]   freq_nx;
   logic          in_pop_st;
   logic          pop;
   logic          legal;
   logic          misfit;
   logic          bad;
   logic [31:0]   sin_w;
   logic [31:0]   cos_w;
   logic          unused_bits;

   assign byte_w  = rx_fifo_data[7:0];
   assign st_len  = rx_fifo_status[MAC_SIZE+IP_SIZE +: LW];
   assign st_ip   = 32'(rx_fifo_status[MAC_SIZE +: IP_SIZE]);
   assign lm5     = len_q - LW'(5);
   assign freq_nx = {freq_q[23:0], byte_w};

   assign unused_bits = ^{rx_fifo_status[MAC_SIZE-1:0], rx_fifo_data};

   assign in_pop_st = (state_q == S_MODE) || (state_q == S_FREQ) ||
                      (state_q == S_SAMPLE) || (state_q == S_FLUSH);

   // Byte pop is qualified by show-ahead empty so one byte moves per cycle.
   assign pop = in_pop_st && !rx_fifo_data_empty && (left_q != '0);

   assign legal = (byte_w == 8'h00) || (byte_w == 8'h0F) ||
                  (byte_w == 8'hF0) || (byte_w == 8'hFF);

   assign misfit = byte_w[0] ? (lm5[2:0] != 3'd0) : (lm5[1:0] != 2'd0);

   assign bad = (len_q < LW'(5)) ||
                (32'(len_q) > 32'(UDP_BYTE_PER_PACKET)) ||
                ((expected_ip != '0) && (ip_q != 32'(expected_ip)));

   always_comb begin
      if (mode_q[0]) begin
         sin_w = smp_q[63:32];
         cos_w = smp_q[31:0];
      end else begin
         sin_w = {{16{smp_q[15]}}, smp_q[15:0]};
         cos_w = {{16{smp_q[31]}}, smp_q[31:16]};
      end
   end

   assign acq_wrdata_fifo_108 = {11'b0, fc_q, freq_q, sin_w, cos_w};
   assign acq_wrreq_fifo_108  = (state_q == S_WRITE) && !acq_wrfull_fifo_108;
   assign rx_fifo_data_read   = pop;
   assign rx_fifo_status_read = srd_q;
   assign rx_mode_nCont_disc  = ncont_q;
   assign rx_mode_nRaw_dem    = nraw_q;
   assign pkt_count           = pkt_q;
   assign err_count           = err_q;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      ip_d    = ip_q;
      left_d  = left_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      freq_d  = freq_q;
      lfreq_d = lfreq_q;
      lvld_d  = lvld_q;
      fc_d    = fc_q;
      smp_d   = smp_q;
      srd_d   = 1'b0;
      ncont_d = ncont_q;
      nraw_d  = nraw_q;
      pkt_d   = pkt_q;
      err_d   = err_q;
      if (pop) begin
         left_d = left_q - LW'(1);
      end
      case (state_q)
         S_IDLE: begin
            if (!rx_fifo_status_empty) begin
               len_d   = st_len;
               ip_d    = st_ip;
               srd_d   = 1'b1;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            left_d  = len_q;
            state_d = bad ? S_FLUSH : S_MODE;
         end
         S_MODE: begin
            if (pop) begin
               if (!legal || misfit) begin
                  state_d = S_FLUSH;
               end else begin
                  mode_d  = {byte_w[7], byte_w[0]};
                  cnt_d   = 3'd0;
                  state_d = S_FREQ;
               end
            end
         end
         S_FREQ: begin
            if (pop) begin
               freq_d = freq_nx;
               cnt_d  = cnt_q + 3'd1;
               if (cnt_q == 3'd3) begin
                  fc_d    = !lvld_q || (freq_nx != lfreq_q);
                  lfreq_d = freq_nx;
                  lvld_d  = 1'b1;
                  cnt_d   = 3'd0;
                  state_d = (left_q == LW'(1)) ? S_DONE : S_SAMPLE;
               end
            end
         end
         S_SAMPLE: begin
            if (pop) begin
               smp_d = {smp_q[55:0], byte_w};
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == (mode_q[0] ? 3'd7 : 3'd3)) begin
                  cnt_d   = 3'd0;
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (!acq_wrfull_fifo_108) begin
               fc_d    = 1'b0;
               state_d = (left_q == '0) ? S_DONE : S_SAMPLE;
            end
         end
         S_DONE: begin
            pkt_d   = pkt_q + 16'd1;
            ncont_d = mode_q[1];
            nraw_d  = mode_q[0];
            state_d = S_IDLE;
         end
         S_FLUSH: begin
            if (left_q == '0) begin
               if (err_q != 16'hFFFF) begin
                  err_d = err_q + 16'd1;
               end
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         ip_q    <= '0;
         left_q  <= '0;
         cnt_q   <= '0;
         mode_q  <= '0;
         freq_q  <= '0;
         lfreq_q <= '0;
         lvld_q  <= 1'b0;
         fc_q    <= 1'b0;
         smp_q   <= '0;
         srd_q   <= 1'b0;
         ncont_q <= 1'b0;
         nraw_q  <= 1'b0;
         pkt_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         ip_q    <= ip_d;
         left_q  <= left_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         freq_q  <= freq_d;
         lfreq_q <= lfreq_d;
         lvld_q  <= lvld_d;
         fc_q    <= fc_d;
         smp_q   <= smp_d;
         srd_q   <= srd_d;
         ncont_q <= ncont_d;
         nraw_q  <= nraw_d;
         pkt_q   <= pkt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_dec_udp_acq_rx.sv
// Scoreboard bench for dec_udp_acq_rx: show-ahead FIFO models feed packets,
// a monitor pops expected 108-bit words whenever the DUT writes.
module tb_dec_udp_acq_rx;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [31:0]   expected_ip = '0;
   logic [7:0]    rx_fifo_data = '0;
   logic          rx_fifo_data_empty = 1'b1;
   logic          rx_fifo_data_read;
   logic [95:0]   rx_fifo_status = '0;
   logic          rx_fifo_status_empty = 1'b1;
   logic          rx_fifo_status_read;
   logic          acq_wrreq_fifo_108;
   logic [107:0]  acq_wrdata_fifo_108;
   logic          acq_wrfull_fifo_108 = 1'b0;
   logic          rx_mode_nCont_disc;
   logic          rx_mode_nRaw_dem;
   logic [15:0]   pkt_count;
   logic [15:0]   err_count;

   int checks = 0;
   int errors = 0;

   logic [7:0]   dq[$];
   logic [95:0]  sq[$];
   logic [107:0] exq[$];

   always #5 clk = ~clk;

   dec_udp_acq_rx dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .expected_ip          (expected_ip),
      .rx_fifo_data         (rx_fifo_data),
      .rx_fifo_data_empty   (rx_fifo_data_empty),
      .rx_fifo_data_read    (rx_fifo_data_read),
      .rx_fifo_status       (rx_fifo_status),
      .rx_fifo_status_empty (rx_fifo_status_empty),
      .rx_fifo_status_read  (rx_fifo_status_read),
      .acq_wrreq_fifo_108   (acq_wrreq_fifo_108),
      .acq_wrdata_fifo_108  (acq_wrdata_fifo_108),
      .acq_wrfull_fifo_108  (acq_wrfull_fifo_108),
      .rx_mode_nCont_disc   (rx_mode_nCont_disc),
      .rx_mode_nRaw_dem     (rx_mode_nRaw_dem),
      .pkt_count            (pkt_count),
      .err_count            (err_count)
   );

   task automatic chk(input string nm, input logic [107:0] act,
                      input logic [107:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   // Show-ahead FIFO models: outputs change at negedge, pops at posedge.
   initial begin
      logic rs, ss;
      forever begin
         @(negedge clk);
         rx_fifo_data_empty   = (dq.size() == 0);
         rx_fifo_data         = (dq.size() != 0) ? dq[0] : 8'h00;
         rx_fifo_status_empty = (sq.size() == 0);
         rx_fifo_status       = (sq.size() != 0) ? sq[0] : 96'h0;
         #4;
         rs = rx_fifo_data_read;
         ss = rx_fifo_status_read;
         if (rs && (dq.size() == 0)) chk("pop_on_empty", 1, 0);
         if (rs && ss) chk("dual_pop", 1, 0);
         @(posedge clk);
         if (rs && (dq.size() != 0)) void'(dq.pop_front());
         if (ss && (sq.size() != 0)) void'(sq.pop_front());
      end
   end

   // Monitor: compare every write against the scoreboard queue.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (reset_n && acq_wrreq_fifo_108) begin
            chk("wr_while_full", 108'(acq_wrfull_fifo_108), 108'h0);
            if (exq.size() == 0) begin
               chk("unexpected_wr", acq_wrdata_fifo_108, 108'h0 - 108'h1);
            end else begin
               chk("wrdata", acq_wrdata_fifo_108, exq.pop_front());
            end
         end
      end
   end

   task automatic pb(input logic [7:0] b);
      dq.push_back(b);
   endtask

   task automatic pw(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) pb(w[8*i +: 8]);
   endtask

   task automatic pst(input logic [15:0] len, input logic [31:0] ip);
      sq.push_back({len, ip, 48'h0011_2233_4455});
   endtask

   task automatic expw(input logic fc, input logic [31:0] f,
                       input logic [31:0] s, input logic [31:0] c);
      exq.push_back({11'b0, fc, f, s, c});
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_done(input int p, input int e);
      int n;
      n = 0;
      while ((pkt_count != 16'(p) || err_count != 16'(e) || exq.size() != 0)
             && n < 3000) begin
         @(negedge clk);
         n++;
      end
      cyc(2);
      chk("pkt_count", 108'(pkt_count), 108'(p));
      chk("err_count", 108'(err_count), 108'(e));
      chk("exp_drained", 108'(exq.size()), 108'h0);
   endtask

   task automatic chk_zero_outs();
      chk("rst_pkt", 108'(pkt_count), 108'h0);
      chk("rst_err", 108'(err_count), 108'h0);
      chk("rst_wrreq", 108'(acq_wrreq_fifo_108), 108'h0);
      chk("rst_wrdata", acq_wrdata_fifo_108, 108'h0);
      chk("rst_reads", 108'({rx_fifo_data_read, rx_fifo_status_read}), 108'h0);
      chk("rst_mode", 108'({rx_mode_nCont_disc, rx_mode_nRaw_dem}), 108'h0);
   endtask

   initial begin
      cyc(3);
      #1;
      chk_zero_outs();
      reset_n = 1'b1;
      cyc(2);

      // Raw packet, two samples, first write carries freq_change
      pb(8'h00); pw(32'h0000_1000);
      pw(32'h8001_7FFF); pw(32'h0002_FFFE);
      expw(1'b1, 32'h0000_1000, 32'h0000_7FFF, 32'hFFFF_8001);
      expw(1'b0, 32'h0000_1000, 32'hFFFF_FFFE, 32'h0000_0002);
      pst(16'd13, 32'h0A00_0002);
      wait_done(1, 0);
      chk("mode_raw", 108'({rx_mode_nCont_disc, rx_mode_nRaw_dem}), 108'h0);

      // Demodulated packets, second repeats the frequency
      pb(8'h0F); pw(32'h1234_5678);
      pw(32'h1122_3344); pw(32'h5566_7788);
      pw(32'hCAFE_BABE); pw(32'hDEAD_BEEF);
      expw(1'b1, 32'h1234_5678, 32'h1122_3344, 32'h5566_7788);
      expw(1'b0, 32'h1234_5678, 32'hCAFE_BABE, 32'hDEAD_BEEF);
      pst(16'd21, 32'h0A00_0002);
      wait_done(2, 0);
      chk("mode_dem", 108'({rx_mode_nCont_disc, rx_mode_nRaw_dem}), 108'h1);
      pb(8'hFF); pw(32'h1234_5678);
      pw(32'h0102_0304); pw(32'hA0B0_C0D0);
      expw(1'b0, 32'h1234_5678, 32'h0102_0304, 32'hA0B0_C0D0);
      pst(16'd13, 32'h0A00_0002);
      wait_done(3, 0);
      chk("mode_disc_dem", 108'({rx_mode_nCont_disc, rx_mode_nRaw_dem}), 108'h3);

      // Malformed packets are flushed whole
      pw(32'h0001_0203);
      pst(16'd4, 32'h0A00_0002);
      pb(8'h3C); pw(32'h0000_1000); pw(32'h0000_0000);
      pst(16'd9, 32'h0A00_0002);
      pb(8'h00); pw(32'h0000_1000); pb(8'h01); pb(8'h02);
      pst(16'd7, 32'h0A00_0002);
      wait_done(3, 3);
      chk("flush_all", 108'(dq.size()), 108'h0);
      pb(8'hF0); pw(32'h0000_1000); pw(32'h1234_5678);
      expw(1'b1, 32'h0000_1000, 32'h0000_5678, 32'h0000_1234);
      pst(16'd9, 32'h0A00_0002);
      wait_done(4, 3);
      chk("mode_disc_raw", 108'({rx_mode_nCont_disc, rx_mode_nRaw_dem}), 108'h2);

      // Source IP filter
      expected_ip = 32'h0A00_0001;
      pb(8'h00); pw(32'h0000_1000); pw(32'h0000_0000);
      pst(16'd9, 32'h0A00_0002);
      wait_done(4, 4);

      // Backpressure during a demodulated stream
      pb(8'h0F); pw(32'h0000_1000);
      pw(32'h0000_0001); pw(32'h0000_0002);
      pw(32'h8000_0000); pw(32'h7FFF_FFFF);
      pw(32'hFFFF_FFFF); pw(32'h0000_0000);
      expw(1'b0, 32'h0000_1000, 32'h0000_0001, 32'h0000_0002);
      expw(1'b0, 32'h0000_1000, 32'h8000_0000, 32'h7FFF_FFFF);
      expw(1'b0, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0000_0000);
      pst(16'd29, 32'h0A00_0001);
      cyc(10);
      acq_wrfull_fifo_108 = 1'b1;
      cyc(20);
      chk("bp_held", 108'(exq.size()), 108'h3);
      acq_wrfull_fifo_108 = 1'b0;
      wait_done(5, 4);
      expected_ip = '0;

      // Data FIFO runs dry mid-sample
      pb(8'h00); pw(32'h0000_2000); pb(8'h11); pb(8'h22);
      expw(1'b1, 32'h0000_2000, 32'h0000_3344, 32'h0000_1122);
      expw(1'b0, 32'h0000_2000, 32'hFFFF_BBCC, 32'hFFFF_99AA);
      pst(16'd13, 32'h0A00_0002);
      cyc(50);
      chk("stall_pkt", 108'(pkt_count), 108'h5);
      chk("stall_nowr", 108'(exq.size()), 108'h2);
      pb(8'h33); pb(8'h44); pw(32'h99AA_BBCC);
      wait_done(6, 4);

      // Reset in the middle of a sample
      pb(8'h0F); pw(32'h0000_2000);
      pw(32'h0101_0101); pw(32'h0202_0202);
      pw(32'h0303_0303); pw(32'h0404_0404);
      pst(16'd21, 32'h0A00_0002);
      cyc(9);
      #1;
      reset_n = 1'b0;
      #1;
      chk_zero_outs();
      dq.delete();
      sq.delete();
      cyc(3);
      reset_n = 1'b1;
      cyc(2);
      pb(8'h00); pw(32'h0000_2000); pw(32'h0005_0006);
      expw(1'b1, 32'h0000_2000, 32'h0000_0006, 32'h0000_0005);
      pst(16'd9, 32'h0A00_0002);
      wait_done(1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
